// File: rtl/updown_level_fsm.sv
// -----------------------------------------------------------------------------
// updown_level_fsm
//
// Parametrised up/down level state machine. A direction request (en/up) is
// filtered by a dwell counter: the same direction must be held for DWELL
// enabled cycles before the level moves by STEP. At the range limits the
// level either saturates or wraps modulo the range (WRAP). A synchronous
// load overrides any move and clamps the loaded value into the range.
// All outputs are registered; at_max/at_min always describe the y value
// that is registered on the same edge.
// -----------------------------------------------------------------------------
module updown_level_fsm #(
  parameter int WIDTH   = 4,
  parameter int MIN_LVL = 0,
  parameter int MAX_LVL = 15,
  parameter int STEP    = 1,
  parameter int DWELL   = 1,
  parameter int WRAP    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic             at_max,
  output logic             at_min,
  output logic             limit_hit
);

  // Level arithmetic is done one bit wider than y so that y+STEP and the
  // wrap intermediates never overflow before the range check.
  localparam int EW = WIDTH + 1;

  // Dwell counter only ever holds 0..DWELL.
  localparam int CW = $clog2(DWELL + 1);

  localparam logic [EW-1:0]    MIN_E   = EW'(MIN_LVL);
  localparam logic [EW-1:0]    MAX_E   = EW'(MAX_LVL);
  localparam logic [EW-1:0]    STEP_E  = EW'(STEP);
  localparam logic [EW-1:0]    RANGE_E = EW'(MAX_LVL - MIN_LVL + 1);
  // A downward move from any y below this bound would leave the range.
  localparam logic [EW-1:0]    LOW_E   = EW'(MIN_LVL + STEP);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_LVL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_LVL);
  localparam logic [CW-1:0]    DWELL_C = CW'(DWELL);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  // IDLE: no direction run in progress (count is zero).
  // COUNT: a same-direction run is being accumulated.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   cnt_run;
  logic            dir, dir_nxt;
  logic            move;

  logic [WIDTH-1:0] y_nxt;
  logic             at_max_nxt;
  logic             at_min_nxt;
  logic             hit_nxt;

  logic [EW-1:0]    y_e;
  logic [EW-1:0]    lv_e;
  logic [EW-1:0]    up_sum;

  assign y_e    = {1'b0, y};
  assign lv_e   = {1'b0, load_val};
  assign up_sum = y_e + STEP_E;

  // State register: FSM state, dwell run, stored direction and the
  // registered outputs all update together on the clock edge.
  // NOTE: reset is asynchronous so y/at_min change as soon as reset_n falls,
  // and every register here is reset -- there is no storage array to exempt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dir       <= 1'b1;
      y         <= MIN_W;
      at_max    <= 1'b0;
      at_min    <= 1'b1;
      limit_hit <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational processes.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      y         <= y_nxt;
      at_max    <= at_max_nxt;
      at_min    <= at_min_nxt;
      limit_hit <= hit_nxt;
    end
  end

  // Next-state logic: dwell filter deciding when a move is accepted.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    move      = 1'b0;
    // A changed direction (or a fresh run) counts its own cycle as the first.
    cnt_run   = ((state == COUNT) && (up == dir)) ? cnt + CNT_ONE : CNT_ONE;

    if (load) begin
      // Load wins over any request; the run is abandoned, direction kept.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      dir_nxt = up;
      if (cnt_run == DWELL_C) begin
        move      = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = COUNT;
        cnt_nxt   = cnt_run;
      end
    end
  end

  // Output logic: next level, limit pulse and limit flags.
  always_comb begin
    y_nxt   = y;
    hit_nxt = 1'b0;

    if (load) begin
      if (lv_e < MIN_E) begin
        y_nxt   = MIN_W;
        hit_nxt = 1'b1;
      end else if (lv_e > MAX_E) begin
        y_nxt   = MAX_W;
        hit_nxt = 1'b1;
      end else begin
        y_nxt   = load_val;
      end
    end else if (move) begin
      if (up) begin
        if (up_sum > MAX_E) begin
          // Overflow: wrap by subtracting the range size, else saturate.
          hit_nxt = 1'b1;
          y_nxt   = (WRAP != 0) ? WIDTH'(up_sum - RANGE_E) : MAX_W;
        end else begin
          y_nxt   = WIDTH'(up_sum);
        end
      end else begin
        if (y_e < LOW_E) begin
          // Underflow: adding the range before subtracting STEP keeps the
          // wrap intermediate non-negative.
          hit_nxt = 1'b1;
          y_nxt   = (WRAP != 0) ? WIDTH'(y_e + RANGE_E - STEP_E) : MIN_W;
        end else begin
          y_nxt   = WIDTH'(y_e - STEP_E);
        end
      end
    end

    at_max_nxt = (y_nxt == MAX_W);
    at_min_nxt = (y_nxt == MIN_W);
  end

endmodule

// File: tb/tb_updown_level_fsm.sv
// -----------------------------------------------------------------------------
// tb_updown_level_fsm
//
// Directed bench for updown_level_fsm. Four configurations share one set of
// stimulus inputs; each scenario task resets, drives its vectors and compares
// the relevant instance against hand-computed expected values. Outputs are
// sampled 1 time unit after the rising edge; inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_updown_level_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] load_val2;

  int errors = 0;
  int checks = 0;

  // legacy: WIDTH=2, 0..3, STEP=1, DWELL=1, saturate
  logic [1:0] leg_y;
  logic       leg_max, leg_min, leg_lh;
  // wrap: WIDTH=4, 0..15, STEP=3, DWELL=1, wrap
  logic [3:0] wrp_y;
  logic       wrp_max, wrp_min, wrp_lh;
  // dwell: WIDTH=4, 0..15, STEP=1, DWELL=3, saturate
  logic [3:0] dwl_y;
  logic       dwl_max, dwl_min, dwl_lh;
  // clamp: WIDTH=4, 2..12, STEP=1, DWELL=1, saturate
  logic [3:0] clp_y;
  logic       clp_max, clp_min, clp_lh;

  always #5 clk = ~clk;

  updown_level_fsm #(.WIDTH(2), .MIN_LVL(0), .MAX_LVL(3), .STEP(1), .DWELL(1), .WRAP(0)) u_leg (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val2),
    .y(leg_y), .at_max(leg_max), .at_min(leg_min), .limit_hit(leg_lh));

  updown_level_fsm #(.WIDTH(4), .MIN_LVL(0), .MAX_LVL(15), .STEP(3), .DWELL(1), .WRAP(1)) u_wrp (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .y(wrp_y), .at_max(wrp_max), .at_min(wrp_min), .limit_hit(wrp_lh));

  updown_level_fsm #(.WIDTH(4), .MIN_LVL(0), .MAX_LVL(15), .STEP(1), .DWELL(3), .WRAP(0)) u_dwl (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .y(dwl_y), .at_max(dwl_max), .at_min(dwl_min), .limit_hit(dwl_lh));

  updown_level_fsm #(.WIDTH(4), .MIN_LVL(2), .MAX_LVL(12), .STEP(1), .DWELL(1), .WRAP(0)) u_clp (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .y(clp_y), .at_max(clp_max), .at_min(clp_min), .limit_hit(clp_lh));

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and release it just after an edge with inputs idle.
  task automatic do_reset();
    en       = 1'b0;
    up       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    reset_n  = 1'b0;
    step();
    reset_n  = 1'b1;
  endtask

  task automatic test_reset();
    en        = 1'b0;
    up        = 1'b0;
    load      = 1'b0;
    load_val  = 4'd0;
    load_val2 = 2'd0;
    reset_n   = 1'b0;
    #12;
    checks++;
    if ({leg_y, leg_max, leg_min, leg_lh} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_leg got y=%0d max=%b min=%b lh=%b want y=0 max=0 min=1 lh=0",
               leg_y, leg_max, leg_min, leg_lh);
    end
    checks++;
    if ({wrp_y, wrp_max, wrp_min, wrp_lh} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_wrap got y=%0d max=%b min=%b lh=%b want y=0 max=0 min=1 lh=0",
               wrp_y, wrp_max, wrp_min, wrp_lh);
    end
    checks++;
    if ({clp_y, clp_max, clp_min, clp_lh} !== {4'd2, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_clamp got y=%0d max=%b min=%b lh=%b want y=2 max=0 min=1 lh=0",
               clp_y, clp_max, clp_min, clp_lh);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_legacy();
    int ey_up[5] = '{1, 2, 3, 3, 3};
    int eh_up[5] = '{0, 0, 0, 1, 1};
    int ey_dn[4] = '{2, 1, 0, 0};
    int eh_dn[4] = '{0, 0, 0, 1};
    do_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({leg_y, leg_max, leg_min, leg_lh} !==
          {2'(ey_up[i]), (ey_up[i] == 3), (ey_up[i] == 0), 1'(eh_up[i])}) begin
        errors++;
        $display("FAIL legacy_up[%0d] got y=%0d max=%b min=%b lh=%b want y=%0d lh=%0d",
                 i, leg_y, leg_max, leg_min, leg_lh, ey_up[i], eh_up[i]);
      end
    end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({leg_y, leg_max, leg_min, leg_lh} !==
          {2'(ey_dn[i]), (ey_dn[i] == 3), (ey_dn[i] == 0), 1'(eh_dn[i])}) begin
        errors++;
        $display("FAIL legacy_dn[%0d] got y=%0d max=%b min=%b lh=%b want y=%0d lh=%0d",
                 i, leg_y, leg_max, leg_min, leg_lh, ey_dn[i], eh_dn[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    load     = 1'b1;
    load_val = 4'd14;
    step();
    checks++;
    if ({wrp_y, wrp_lh} !== {4'd14, 1'b0}) begin
      errors++;
      $display("FAIL wrap_load got y=%0d lh=%b want y=14 lh=0", wrp_y, wrp_lh);
    end
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    step();
    checks++;
    if ({wrp_y, wrp_max, wrp_min, wrp_lh} !== {4'd1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_up got y=%0d max=%b min=%b lh=%b want y=1 max=0 min=0 lh=1",
               wrp_y, wrp_max, wrp_min, wrp_lh);
    end
    up = 1'b0;
    step();
    checks++;
    if ({wrp_y, wrp_lh} !== {4'd14, 1'b1}) begin
      errors++;
      $display("FAIL wrap_down got y=%0d lh=%b want y=14 lh=1", wrp_y, wrp_lh);
    end
    en = 1'b0;
    step();
    checks++;
    if ({wrp_y, wrp_lh} !== {4'd14, 1'b0}) begin
      errors++;
      $display("FAIL wrap_pulse_end got y=%0d lh=%b want y=14 lh=0", wrp_y, wrp_lh);
    end
  endtask

  task automatic test_dwell();
    int ey_hold[7] = '{0, 0, 1, 1, 1, 2, 2};
    int dirs[5]    = '{1, 1, 0, 0, 0};
    int ey_pat[5]  = '{2, 2, 2, 2, 1};
    do_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if ({dwl_y, dwl_lh} !== {4'(ey_hold[i]), 1'b0}) begin
        errors++;
        $display("FAIL dwell_hold[%0d] got y=%0d lh=%b want y=%0d lh=0",
                 i, dwl_y, dwl_lh, ey_hold[i]);
      end
    end
    en = 1'b0;
    step();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up = dirs[i][0];
      step();
      checks++;
      if ({dwl_y, dwl_lh} !== {4'(ey_pat[i]), 1'b0}) begin
        errors++;
        $display("FAIL dwell_pattern[%0d] got y=%0d lh=%b want y=%0d lh=0",
                 i, dwl_y, dwl_lh, ey_pat[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_reset();
    load     = 1'b1;
    load_val = 4'd15;
    step();
    checks++;
    if ({clp_y, clp_max, clp_min, clp_lh} !== {4'd12, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clamp_high got y=%0d max=%b min=%b lh=%b want y=12 max=1 min=0 lh=1",
               clp_y, clp_max, clp_min, clp_lh);
    end
    load_val = 4'd0;
    step();
    checks++;
    if ({clp_y, clp_max, clp_min, clp_lh} !== {4'd2, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL clamp_low got y=%0d max=%b min=%b lh=%b want y=2 max=0 min=1 lh=1",
               clp_y, clp_max, clp_min, clp_lh);
    end
    load_val = 4'd7;
    step();
    checks++;
    if ({clp_y, clp_max, clp_min, clp_lh} !== {4'd7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clamp_inside got y=%0d max=%b min=%b lh=%b want y=7 max=0 min=0 lh=0",
               clp_y, clp_max, clp_min, clp_lh);
    end
    load_val = 4'd5;
    en       = 1'b1;
    up       = 1'b1;
    step();
    checks++;
    if ({clp_y, clp_lh} !== {4'd5, 1'b0}) begin
      errors++;
      $display("FAIL load_priority got y=%0d lh=%b want y=5 lh=0", clp_y, clp_lh);
    end
    load = 1'b0;
    step();
    checks++;
    if ({clp_y, clp_lh} !== {4'd6, 1'b0}) begin
      errors++;
      $display("FAIL move_after_load got y=%0d lh=%b want y=6 lh=0", clp_y, clp_lh);
    end
    en = 1'b0;
  endtask

  task automatic test_en_gating();
    int ey_run[3] = '{0, 0, 1};
    do_reset();
    en = 1'b1;
    up = 1'b1;
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up = i[0];
      step();
      checks++;
      if ({dwl_y, dwl_min, dwl_lh} !== {4'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL en_low[%0d] got y=%0d min=%b lh=%b want y=0 min=1 lh=0",
                 i, dwl_y, dwl_min, dwl_lh);
      end
    end
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dwl_y !== 4'(ey_run[i])) begin
        errors++;
        $display("FAIL en_rerun[%0d] got y=%0d want y=%0d", i, dwl_y, ey_run[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ey_run[3] = '{0, 0, 1};
    do_reset();
    load     = 1'b1;
    load_val = 4'd9;
    step();
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    step();
    step();
    checks++;
    if (dwl_y !== 4'd9) begin
      errors++;
      $display("FAIL mid_setup got y=%0d want y=9", dwl_y);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dwl_y, dwl_max, dwl_min, dwl_lh} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_async_reset got y=%0d max=%b min=%b lh=%b want y=0 max=0 min=1 lh=0",
               dwl_y, dwl_max, dwl_min, dwl_lh);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dwl_y !== 4'(ey_run[i])) begin
        errors++;
        $display("FAIL mid_rerun[%0d] got y=%0d want y=%0d", i, dwl_y, ey_run[i]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_wrap();
    test_dwell();
    test_load_clamp();
    test_en_gating();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time limit on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "time limit expired");
  end

endmodule
